// File: rtl/fp_norm_pkg.sv
// Shared types and constants for the fp_normalizer post-add normalization stage.
package fp_norm_pkg;

  localparam int MANT_W = 16;

  typedef enum logic [1:0] {IDLE, PREP, SHIFT, DONE} state_t;

  // Largest exponent code; reserved for infinity/overflow.
  function automatic int exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

endpackage

// File: rtl/fp_lzc16.sv
// Combinational 16-bit leading-zero counter; returns 16 for an all-zero input.
module fp_lzc16 (
  input  logic [15:0] d,
  output logic [4:0]  cnt
);

  // Scan upward so the highest set bit is the last assignment to win.
  always_comb begin
    cnt = 5'd16;
    for (int i = 0; i < 16; i++) begin
      if (d[i]) cnt = 5'(15 - i);
    end
  end

endmodule

// File: rtl/fp_normalizer.sv
// Post-add normalizer: one left shift per cycle, or single-cycle shift when
// FP_NORM_FAST_EN is defined (leading-zero count in PREP).
module fp_normalizer
  import fp_norm_pkg::*;
#(
  parameter int EXP_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       mant_in,
  input  logic              carry_in,
  input  logic              neg_in,
  input  logic              sign_in,
  input  logic [EXP_W-1:0]  exp_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       mant_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic              sign_out,
  output logic              zero_out,
  output logic              ovf_out,
  output logic              udf_out
);

  localparam int EMAX_I = exp_max(EXP_W);

  state_t             state, state_n;
  logic [MANT_W-1:0]  m_r, m_n, m_abs, m_shl;
  logic [EXP_W-1:0]   e_r, e_n, e_dec;
  logic [EXP_W:0]     e_inc;
  logic               sign_r, sign_n, zero_r, zero_n, ovf_r, ovf_n, udf_r, udf_n;
  logic               carry_r, carry_n, neg_r, neg_n;

  assign m_abs = neg_r ? (~m_r + 16'd1) : m_r;
  assign m_shl = {m_r[MANT_W-2:0], 1'b0};
  assign e_inc = {1'b0, e_r} + {{EXP_W{1'b0}}, 1'b1};
  assign e_dec = e_r - {{(EXP_W-1){1'b0}}, 1'b1};

`ifdef FP_NORM_FAST_EN
  logic [4:0]        lz;
  int                shamt;
  logic [MANT_W-1:0] m_fast;

  fp_lzc16 u_lzc (.d(m_abs), .cnt(lz));

  // Shift is capped by the exponent so a denormal stops at e == 0.
  always_comb begin
    shamt  = (int'(lz) < int'(e_r)) ? int'(lz) : int'(e_r);
    m_fast = m_abs << shamt;
  end
`endif

  always_comb begin
    state_n = state;
    m_n     = m_r;
    e_n     = e_r;
    sign_n  = sign_r;
    zero_n  = zero_r;
    ovf_n   = ovf_r;
    udf_n   = udf_r;
    carry_n = carry_r;
    neg_n   = neg_r;
    case (state)
      IDLE: begin
        if (in_valid) begin
          m_n     = mant_in;
          e_n     = exp_in;
          sign_n  = sign_in;
          carry_n = carry_in;
          neg_n   = neg_in;
          zero_n  = 1'b0;
          ovf_n   = 1'b0;
          udf_n   = 1'b0;
          state_n = PREP;
        end
      end
      PREP: begin
        sign_n  = neg_r ? ~sign_r : sign_r;
        state_n = DONE;
        if (!neg_r && carry_r) begin
          m_n = {1'b1, m_r[MANT_W-1:1]};
          e_n = e_inc[EXP_W-1:0];
          if (int'(e_inc) >= EMAX_I) begin
            ovf_n = 1'b1;
            e_n   = EXP_W'(EMAX_I);
            m_n   = '0;
          end
        end else if (m_abs == '0) begin
          m_n    = '0;
          e_n    = '0;
          zero_n = 1'b1;
          sign_n = 1'b0;
        end else begin
`ifdef FP_NORM_FAST_EN
          m_n   = m_fast;
          e_n   = e_r - EXP_W'(shamt);
          udf_n = ~m_fast[MANT_W-1];
`else
          m_n = m_abs;
          if (!m_abs[MANT_W-1]) begin
            if (e_r == '0) udf_n = 1'b1;
            else           state_n = SHIFT;
          end
`endif
        end
      end
      SHIFT: begin
        m_n = m_shl;
        e_n = e_dec;
        if (m_shl[MANT_W-1]) begin
          state_n = DONE;
        end else if (e_dec == '0) begin
          udf_n   = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      m_r     <= '0;
      e_r     <= '0;
      sign_r  <= 1'b0;
      zero_r  <= 1'b0;
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
      carry_r <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      state   <= state_n;
      m_r     <= m_n;
      e_r     <= e_n;
      sign_r  <= sign_n;
      zero_r  <= zero_n;
      ovf_r   <= ovf_n;
      udf_r   <= udf_n;
      carry_r <= carry_n;
      neg_r   <= neg_n;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign mant_out  = m_r;
  assign exp_out   = e_r;
  assign sign_out  = sign_r;
  assign zero_out  = zero_r;
  assign ovf_out   = ovf_r;
  assign udf_out   = udf_r;

endmodule

// File: tb/tb_fp_normalizer.sv
// Self-checking bench for fp_normalizer: directed cases plus randomized operands
// against an arithmetic reference model.
module tb_fp_normalizer;

  localparam int EXP_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [15:0]      mant_in, mant_out;
  logic             carry_in, neg_in, sign_in;
  logic [EXP_W-1:0] exp_in, exp_out;
  logic             sign_out, zero_out, ovf_out, udf_out;
  logic [24:0]      obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_normalizer #(.EXP_W(EXP_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .mant_in(mant_in), .carry_in(carry_in), .neg_in(neg_in),
    .sign_in(sign_in), .exp_in(exp_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .mant_out(mant_out), .exp_out(exp_out), .sign_out(sign_out),
    .zero_out(zero_out), .ovf_out(ovf_out), .udf_out(udf_out)
  );

  // Packed result: {mant, exp, sign, zero, ovf, udf}
  assign obs = {mant_out, exp_out, sign_out, zero_out, ovf_out, udf_out};

  // Reference: integer magnitude, then double until normalized or exponent hits 0.
  function automatic logic [24:0] model(input logic [15:0] mant, input logic carry,
                                        input logic neg, input logic sign,
                                        input logic [4:0] ex, output int n);
    int m, e;
    logic s, z, o, u;
    n = 0; z = 0; o = 0; u = 0;
    s = neg ? ~sign : sign;
    if (!neg && carry) begin
      m = (65536 + int'(mant)) / 2;
      e = int'(ex) + 1;
      if (e >= 31) begin
        o = 1; e = 31; m = 0;
      end
    end else begin
      m = neg ? (65536 - int'(mant)) % 65536 : int'(mant);
      e = int'(ex);
      if (m == 0) begin
        z = 1; e = 0; s = 0;
      end else begin
        while (m < 32768 && e > 0) begin
          m = m * 2; e = e - 1; n++;
        end
        if (m < 32768) u = 1;
      end
    end
    return {16'(m), 5'(e), s, z, o, u};
  endfunction

  function automatic int exp_lat(input int n);
`ifdef FP_NORM_FAST_EN
    return 1;
`else
    return n + 1;
`endif
  endfunction

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_op(input logic [15:0] mant, input logic carry, input logic neg,
                       input logic sign, input logic [4:0] ex, input int hold,
                       output logic [24:0] res, output int lat);
    mant_in = mant; carry_in = carry; neg_in = neg; sign_in = sign; exp_in = ex;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    res = obs;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hs in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    checks++;
    if (obs !== 25'h0) begin
      errors++; $display("FAIL reset_out got %h want 0", obs);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset in_ready=%b out_valid=%b", in_ready, out_valid);
    end
  endtask

  typedef struct packed {
    logic [15:0] mant; logic carry; logic neg; logic sign; logic [4:0] ex;
    logic [24:0] res; logic [4:0] n;
  } vec_t;

  task automatic test_directed;
    vec_t tv[9];
    logic [24:0] res;
    int lat;
    tv[0] = '{16'h0100, 1'b0, 1'b0, 1'b0, 5'd15, {16'h8000, 5'd8,  4'b0000}, 5'd7};
    tv[1] = '{16'h4000, 1'b1, 1'b0, 1'b0, 5'd10, {16'hA000, 5'd11, 4'b0000}, 5'd0};
    tv[2] = '{16'hFF00, 1'b0, 1'b1, 1'b0, 5'd20, {16'h8000, 5'd13, 4'b1000}, 5'd7};
    tv[3] = '{16'h0000, 1'b0, 1'b0, 1'b1, 5'd9,  {16'h0000, 5'd0,  4'b0100}, 5'd0};
    tv[4] = '{16'h0001, 1'b0, 1'b0, 1'b0, 5'd3,  {16'h0008, 5'd0,  4'b0001}, 5'd3};
    tv[5] = '{16'h0000, 1'b1, 1'b0, 1'b0, 5'd30, {16'h0000, 5'd31, 4'b0010}, 5'd0};
    tv[6] = '{16'h8000, 1'b0, 1'b1, 1'b1, 5'd5,  {16'h8000, 5'd5,  4'b0000}, 5'd0};
    tv[7] = '{16'h0002, 1'b1, 1'b0, 1'b1, 5'd29, {16'h8001, 5'd30, 4'b1000}, 5'd0};
    tv[8] = '{16'h0040, 1'b0, 1'b0, 1'b0, 5'd0,  {16'h0040, 5'd0,  4'b0001}, 5'd0};
    for (int i = 0; i < 9; i++) begin
      do_op(tv[i].mant, tv[i].carry, tv[i].neg, tv[i].sign, tv[i].ex, 0, res, lat);
      checks++;
      if (res !== tv[i].res) begin
        errors++; $display("FAIL directed%0d result got %h want %h", i, res, tv[i].res);
      end
      checks++;
      if (lat != exp_lat(int'(tv[i].n))) begin
        errors++; $display("FAIL directed%0d latency got %0d want %0d", i, lat, exp_lat(int'(tv[i].n)));
      end
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++; $display("FAIL directed%0d release in_ready=%b out_valid=%b", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [24:0] held;
    int lat;
    mant_in = 16'h0000; carry_in = 1'b1; neg_in = 1'b0; sign_in = 1'b0; exp_in = 5'd30;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    held = obs;
    checks++;
    if (held !== {16'h0000, 5'd31, 4'b0010} || lat != 1) begin
      errors++; $display("FAIL bp_ovf got %h lat %0d want %h lat 1", held, lat, {16'h0000, 5'd31, 4'b0010});
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got %h v=%b r=%b want %h v=1 r=0", i, obs, out_valid, in_ready, held);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_midop;
    logic [24:0] res;
    int lat;
    mant_in = 16'h0100; carry_in = 1'b0; neg_in = 1'b0; sign_in = 1'b0; exp_in = 5'd15;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== 25'h0) begin
      errors++; $display("FAIL midop_reset v=%b r=%b out=%h want 0/1/0", out_valid, in_ready, obs);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(16'h4000, 1'b1, 1'b0, 1'b0, 5'd10, 0, res, lat);
    checks++;
    if (res !== {16'hA000, 5'd11, 4'b0000} || lat != 1) begin
      errors++; $display("FAIL midop_next got %h lat %0d want %h lat 1", res, lat, {16'hA000, 5'd11, 4'b0000});
    end
  endtask

  task automatic test_back_to_back;
    logic [24:0] want;
    int n, lat;
    mant_in = 16'hFF00; carry_in = 1'b0; neg_in = 1'b1; sign_in = 1'b0; exp_in = 5'd20;
    in_valid = 1'b1;
    @(posedge clk); #1;
    // Second operand presented immediately; must wait for the first to drain.
    mant_in = 16'h0030; carry_in = 1'b0; neg_in = 1'b0; sign_in = 1'b1; exp_in = 5'd12;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_busy in_ready=%b want 0", in_ready);
    end
    wait_valid(lat);
    want = model(16'hFF00, 1'b0, 1'b1, 1'b0, 5'd20, n);
    checks++;
    if (obs !== want || lat != exp_lat(n)) begin
      errors++; $display("FAIL b2b_first got %h lat %0d want %h lat %0d", obs, lat, want, exp_lat(n));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_idle in_ready=%b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    want = model(16'h0030, 1'b0, 1'b0, 1'b1, 5'd12, n);
    checks++;
    if (obs !== want || lat != exp_lat(n)) begin
      errors++; $display("FAIL b2b_second got %h lat %0d want %h lat %0d", obs, lat, want, exp_lat(n));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_random;
    logic [15:0] mant;
    logic        carry, neg, sign;
    logic [4:0]  ex;
    logic [24:0] res, want;
    int n, lat;
    for (int i = 0; i < 80; i++) begin
      mant  = 16'($urandom_range(0, 65535) >> $urandom_range(0, 16));
      carry = 1'($urandom_range(0, 1));
      neg   = ($urandom_range(0, 3) == 0);
      sign  = 1'($urandom_range(0, 1));
      ex    = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(27, 30)) : 5'($urandom_range(0, 30));
      if (neg && $urandom_range(0, 1) == 1) mant = ~mant;
      want = model(mant, carry, neg, sign, ex, n);
      do_op(mant, carry, neg, sign, ex, $urandom_range(0, 2), res, lat);
      checks++;
      if (res !== want) begin
        errors++; $display("FAIL rand%0d m=%h c=%b n=%b s=%b e=%0d got %h want %h", i, mant, carry, neg, sign, ex, res, want);
      end
      checks++;
      if (lat != exp_lat(n)) begin
        errors++; $display("FAIL rand%0d latency got %0d want %0d", i, lat, exp_lat(n));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    mant_in = '0; carry_in = 1'b0; neg_in = 1'b0; sign_in = 1'b0; exp_in = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_directed;
    test_backpressure;
    test_reset_midop;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_normalizer.md
Name: fp_normalizer

Overview:
- Post-add normalization stage of the 16-bit floating-point adder datapath; sits directly downstream of the mantissa add/sub stage.
- Consumes the raw 16-bit add/sub result, its carry-out, its negative flag and the pre-aligned exponent.
- Produces a normalized magnitude mantissa (leading 1 in bit 15), adjusted exponent, final sign and zero/overflow/underflow flags.
- Iterative: one left shift per cycle under a valid/ready handshake.

Parameters:
EXP_W, 5, exponent width. Exponent all-ones (EXP_MAX = 2^EXP_W-1) is reserved for infinity/overflow.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input operand valid
in_ready  output  1  block can accept; high only in IDLE
mant_in  input  16  raw add/sub result bits [15:0]
carry_in  input  1  add carry-out (result bit 16); ignored when neg_in=1
neg_in  input  1  add/sub result negative (result bit 15 after subtract)
sign_in  input  1  sign of the larger aligned operand
exp_in  input  EXP_W  common (aligned) exponent
out_valid  output  1  result valid; held until accepted
out_ready  input  1  downstream accepts
mant_out  output  16  normalized magnitude mantissa
exp_out  output  EXP_W  adjusted exponent
sign_out  output  1  result sign
zero_out  output  1  result is exact zero
ovf_out  output  1  exponent overflow
udf_out  output  1  underflow/denormal (exponent reached 0 before normalization)

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; in_ready=1.
  - out_valid, mant_out, exp_out, sign_out, zero_out, ovf_out and udf_out all 0.
  - Reset mid-operation discards the in-flight operand.
- States: IDLE, PREP, SHIFT, DONE.
- IDLE: in_valid && in_ready captures all inputs at the clock edge; next state PREP.
- PREP (one cycle): compute the working magnitude m and exponent e.
  - neg_in=1: m = two's complement of mant_in (0x8000 gives 0x8000 unsigned); sign = ~sign_in.
  - neg_in=0: sign = sign_in.
  - neg_in=0, carry_in=1: m = {1, mant_in[15:1]}, e = exp_in+1.
    - If exp_in+1 >= EXP_MAX: ovf=1, e = EXP_MAX, m = 0, go to DONE.
  - m==0 (no carry): zero=1, e=0, sign=0, go to DONE.
  - m[15]==1, or e==0 (udf=1 if m[15]==0): go to DONE.
  - Otherwise go to SHIFT.
- SHIFT: each cycle m <= m<<1, e <= e-1.
  - If the new m[15]==1, go to DONE.
  - Else if the new e==0, set udf=1 and go to DONE.
  - Otherwise stay in SHIFT.
- DONE: out_valid=1 and all outputs registered.
  - Outputs are stable while out_ready=0.
  - On out_valid && out_ready, go to IDLE and clear out_valid next cycle.
  - No same-cycle accept: in_ready=0 in PREP, SHIFT and DONE.
- Latency: out_valid rises 1+n clock edges after the accept edge, where n = shifts performed (0..15).
  - Carry, zero, overflow and already-normalized cases have latency 1.
- Flags are mutually exclusive.

Optional Feature:
FP_NORM_FAST_EN:
- Defined: PREP computes the leading-zero count z of m and applies shift s = min(z, e) in the same cycle.
  - e becomes e-s; udf=1 if the result m[15]==0; go directly to DONE.
  - Latency is always 1; the SHIFT state is unused.
- Undefined: the iterative behaviour above. Final values are identical in both modes; only latency differs.

Decomposition:
- Package fp_norm_pkg holds:
  - the state enum (IDLE/PREP/SHIFT/DONE);
  - the MANT_W=16 constant;
  - the EXP_MAX function of EXP_W.
- Sub-module fp_lzc16: combinational 16-bit leading-zero counter, 5-bit output, 16 for zero.
  - Instantiated only under FP_NORM_FAST_EN.

Test Plan:
1. mant_in=0x0100, neg=0, carry=0, sign_in=0, exp_in=15 -> mant_out=0x8000, exp_out=8, sign_out=0, out_valid 8 edges after accept (1 edge with FP_NORM_FAST_EN).
2. carry=1, mant_in=0x4000, exp_in=10 -> mant_out=0xA000, exp_out=11, flags 0, latency 1.
3. neg=1, mant_in=0xFF00, sign_in=0, exp_in=20 -> mant_out=0x8000, exp_out=13, sign_out=1, latency 8.
4. mant_in=0x0000, neg=0, carry=0, exp_in=9 -> zero_out=1, mant_out=0, exp_out=0, sign_out=0, latency 1; then mant_in=0x0001, exp_in=3 -> mant_out=0x0008, exp_out=0, udf_out=1, latency 4.
5. carry=1, mant_in=0x0000, exp_in=30 -> ovf_out=1, exp_out=31, mant_out=0; hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0; release -> IDLE, in_ready=1 next cycle.
6. Pull rst_n low during SHIFT of case 1 -> out_valid=0, all outputs 0, in_ready=1 immediately (async); the next operand after release is processed normally.
